// File: rtl/deserializer_if.sv
// Handshake bundle for the word deserializer: serial word input plus the
// parallel frame output. o_sum is present only when DESER_SUM_EN is defined.
interface deserializer_if #(
   parameter int DATA_W = 32,
   parameter int N      = 16
);
   localparam int OCNT_W = $clog2(N + 1);

   logic                     i_valid;
   logic                     i_ready;
   logic signed [DATA_W-1:0] i_data;
   logic                     o_valid;
   logic                     o_ready;
   logic signed [DATA_W-1:0] o_data [N];
   logic [OCNT_W-1:0]        o_count;
`ifdef DESER_SUM_EN
   logic signed [DATA_W+$clog2(N)-1:0] o_sum;
`endif

   modport slave (
      input  i_valid, i_data, o_ready,
      output i_ready, o_valid, o_data, o_count
`ifdef DESER_SUM_EN
      , output o_sum
`endif
   );

   modport master (
      output i_valid, i_data, o_ready,
      input  i_ready, o_valid, o_data, o_count
`ifdef DESER_SUM_EN
      , input o_sum
`endif
   );
endinterface

// File: rtl/deserializer.sv
// Collects N signed words into a parallel frame, first word in o_data[0].
// Optional running frame sum on o_sum when DESER_SUM_EN is defined.
module deserializer #(
   parameter int DATA_W = 32,
   parameter int N      = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   deserializer_if.slave  bus
);
   localparam int CNT_W  = $clog2(N);
   localparam int OCNT_W = $clog2(N + 1);

   typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_t;

   state_t                   state_r, state_s;
   logic [CNT_W-1:0]         cnt_r, cnt_s;
   logic [OCNT_W-1:0]        count_r, count_s;
   logic                     valid_r, valid_s;
   logic                     wr_en_s;
   logic [CNT_W-1:0]         wr_idx_s;
   logic                     i_ready_s;
   logic                     in_xfer_s;
   logic                     out_xfer_s;
   logic signed [DATA_W-1:0] data_r [N];

   assign i_ready_s  = (state_r == HOLD) ? (bus.o_ready & ~clr) : ~clr;
   assign in_xfer_s  = bus.i_valid & i_ready_s;
   assign out_xfer_s = valid_r & bus.o_ready;

   assign bus.i_ready = i_ready_s;
   assign bus.o_valid = valid_r;
   assign bus.o_count = count_r;
   assign bus.o_data  = data_r;

   // Next-state, write-enable and counter decode; clr overrides any handshake.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      count_s  = count_r;
      valid_s  = valid_r;
      wr_en_s  = 1'b0;
      wr_idx_s = cnt_r;
      if (clr) begin
         state_s = FILL;
         cnt_s   = {CNT_W{1'b0}};
         count_s = {OCNT_W{1'b0}};
         valid_s = 1'b0;
      end else begin
         case (state_r)
            FILL: begin
               if (in_xfer_s) begin
                  wr_en_s = 1'b1;
                  if (cnt_r == CNT_W'(N - 1)) begin
                     state_s = HOLD;
                     cnt_s   = {CNT_W{1'b0}};
                     count_s = OCNT_W'(N);
                     valid_s = 1'b1;
                  end else begin
                     cnt_s   = cnt_r + CNT_W'(1);
                     count_s = OCNT_W'(cnt_r) + OCNT_W'(1);
                  end
               end else begin
                  wr_en_s = 1'b0;
               end
            end
            HOLD: begin
               // An input transfer here implies an output transfer, so the
               // next frame starts in the same cycle the held one leaves.
               if (out_xfer_s) begin
                  state_s = FILL;
                  valid_s = 1'b0;
                  if (in_xfer_s) begin
                     wr_en_s  = 1'b1;
                     wr_idx_s = {CNT_W{1'b0}};
                     cnt_s    = CNT_W'(1);
                     count_s  = OCNT_W'(1);
                  end else begin
                     cnt_s    = {CNT_W{1'b0}};
                     count_s  = {OCNT_W{1'b0}};
                  end
               end else begin
                  state_s = HOLD;
               end
            end
            default: begin
               state_s = FILL;
               cnt_s   = {CNT_W{1'b0}};
               count_s = {OCNT_W{1'b0}};
               valid_s = 1'b0;
            end
         endcase
      end
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= FILL;
         cnt_r   <= {CNT_W{1'b0}};
         count_r <= {OCNT_W{1'b0}};
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         count_r <= count_s;
         valid_r <= valid_s;
      end
   end

   // Frame storage; clr leaves contents untouched, only reset zeroes them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            data_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_en_s) begin
         data_r[wr_idx_s] <= bus.i_data;
      end else begin
         data_r <= data_r;
      end
   end

`ifdef DESER_SUM_EN
   localparam int SUM_W = DATA_W + $clog2(N);

   logic signed [SUM_W-1:0] sum_r;
   logic signed [SUM_W-1:0] word_ext_s;

   assign word_ext_s = {{(SUM_W - DATA_W){bus.i_data[DATA_W-1]}}, bus.i_data};
   assign bus.o_sum  = sum_r;

   // Running sum, restarted by the word that lands in slot 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_r <= {SUM_W{1'b0}};
      end else if (clr) begin
         sum_r <= {SUM_W{1'b0}};
      end else if (wr_en_s) begin
         if (wr_idx_s == {CNT_W{1'b0}}) begin
            sum_r <= word_ext_s;
         end else begin
            sum_r <= sum_r + word_ext_s;
         end
      end else begin
         sum_r <= sum_r;
      end
   end
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the deserializer (N=16, DATA_W=32).
module tb_deserializer;
   localparam int DATA_W = 32;
   localparam int N      = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   int   checks_r = 0;
   int   errors_r = 0;

   always #5 clk = ~clk;

   deserializer_if #(.DATA_W(DATA_W), .N(N)) bus ();

   deserializer #(.DATA_W(DATA_W), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks_r++;
      if (act !== exp) begin
         errors_r++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word and wait (bounded) until it is accepted.
   task automatic push(input logic signed [DATA_W-1:0] v);
      int w;
      w = 0;
      bus.i_valid = 1'b1;
      bus.i_data  = v;
      #1;
      while (!bus.i_ready && w < 32) begin
         tick();
         w++;
      end
      if (w >= 32) check("push_timeout", bus.i_ready, 1);
      tick();
   endtask

   initial begin
      rst_n       = 1'b0;
      clr         = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.o_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_o_valid", bus.o_valid, 0);
      check("rst_o_count", bus.o_count, 0);
      check("rst_o_data0", bus.o_data[0], 0);
      check("rst_i_ready", bus.i_ready, 1);

      // 1: back-to-back 1..16
      bus.o_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         push(k);
         if (k == 1)  check("t1_count1", bus.o_count, 1);
         if (k == 15) check("t1_valid_early", bus.o_valid, 0);
         if (k == 15) check("t1_count15", bus.o_count, 15);
      end
      bus.i_valid = 1'b0;
      check("t1_o_valid", bus.o_valid, 1);
      check("t1_o_count", bus.o_count, 16);
      for (int i = 0; i < N; i++) check("t1_o_data", bus.o_data[i], i + 1);
`ifdef DESER_SUM_EN
      check("t1_o_sum", bus.o_sum, 136);
`endif
      tick();
      check("t1_drain_valid", bus.o_valid, 0);
      check("t1_drain_count", bus.o_count, 0);

      // 2: held frame with consumer stalled for 5 cycles
      bus.o_ready = 1'b0;
      for (int k = 0; k < 16; k++) push(100 + k);
      bus.i_valid = 1'b1;
      bus.i_data  = 999;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("t2_i_ready_stall", bus.i_ready, 0);
         tick();
         check("t2_o_valid", bus.o_valid, 1);
         check("t2_o_data0", bus.o_data[0], 100);
         check("t2_o_data15", bus.o_data[15], 115);
      end
      bus.i_valid = 1'b0;
      bus.o_ready = 1'b1;
      tick();
      check("t2_xfer_valid", bus.o_valid, 0);
      check("t2_xfer_count", bus.o_count, 0);

      // 3: two frames streamed with no bubble
      for (int k = 1; k <= 32; k++) begin
         bus.i_valid = 1'b1;
         bus.i_data  = k;
         #1;
         if (k == 17) check("t3_handoff_i_ready", bus.i_ready, 1);
         push(k);
         if (k == 16) begin
            check("t3_f1_valid", bus.o_valid, 1);
            check("t3_f1_data0", bus.o_data[0], 1);
            check("t3_f1_data15", bus.o_data[15], 16);
         end
         if (k == 17) begin
            check("t3_handoff_valid", bus.o_valid, 0);
            check("t3_handoff_count", bus.o_count, 1);
            check("t3_handoff_data0", bus.o_data[0], 17);
         end
      end
      bus.i_valid = 1'b0;
      check("t3_f2_valid", bus.o_valid, 1);
      check("t3_f2_data0", bus.o_data[0], 17);
      check("t3_f2_data15", bus.o_data[15], 32);
`ifdef DESER_SUM_EN
      check("t3_f2_sum", bus.o_sum, 392);
`endif
      tick();

      // 4: clr after 7 words
      for (int k = 0; k < 7; k++) push(50 + k);
      check("t4_count7", bus.o_count, 7);
      clr         = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_data  = 777;
      #1;
      check("t4_clr_i_ready", bus.i_ready, 0);
      tick();
      clr = 1'b0;
      check("t4_clr_count", bus.o_count, 0);
      check("t4_clr_valid", bus.o_valid, 0);
      check("t4_clr_retained", bus.o_data[0], 50);
      for (int k = 0; k < 16; k++) push(200 + k);
      bus.i_valid = 1'b0;
      check("t4_valid", bus.o_valid, 1);
      check("t4_data0", bus.o_data[0], 200);
      check("t4_data7", bus.o_data[7], 207);
      check("t4_data15", bus.o_data[15], 215);
`ifdef DESER_SUM_EN
      check("t4_sum", bus.o_sum, 3320);
`endif
      tick();

      // 5: sixteen words of -1, held
      bus.o_ready = 1'b0;
      for (int k = 0; k < 16; k++) push(-1);
      bus.i_valid = 1'b0;
      check("t5_valid", bus.o_valid, 1);
      check("t5_count", bus.o_count, 16);
      for (int i = 0; i < N; i++) check("t5_o_data", bus.o_data[i], -1);
`ifdef DESER_SUM_EN
      check("t5_sum", bus.o_sum, -16);
`endif

      // 6: reset while holding
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t6_valid", bus.o_valid, 0);
      check("t6_count", bus.o_count, 0);
      for (int i = 0; i < N; i++) check("t6_o_data", bus.o_data[i], 0);
      check("t6_i_ready", bus.i_ready, 1);
`ifdef DESER_SUM_EN
      check("t6_sum", bus.o_sum, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end
endmodule
